// File: rtl/countdown_timer_ctrl.sv
// countdown_timer_ctrl
// Sequencing controller for the one-second tick generator. It loads a
// minutes:seconds preset, drives the generator's run-enable, frequency and
// reset lines, and counts generator ticks down to 00:00.
//
// Optional feature macro: AUTO_RELOAD_EN. When defined, reaching 00:00
// pulses o_done and reloads the preset latched at the last start from IDLE,
// so the block stays in RUN and never enters DONE.
//
// Ports:
//   clk, reset    system clock, synchronous active-high reset
//   i_start       start (IDLE) / resume (PAUSE) / acknowledge (DONE) pulse
//   i_pause       pause pulse, acts in RUN only
//   i_clear       abort to IDLE from any state
//   i_load_min    preset minutes (clamped to 99)
//   i_load_sec    preset seconds (clamped to 59)
//   i_tick        one-cycle tick from the generator
//   o_run_en      generator run enable
//   o_freq        generator period word, constant P_FREQ
//   o_gen_reset   one-cycle generator reset pulse
//   o_min, o_sec  current count
//   o_state       IDLE=0, RUN=1, PAUSE=2, DONE=3
//   o_done        one-cycle pulse on reaching 00:00
//   o_alarm       high while in DONE
module countdown_timer_ctrl #(
  parameter int unsigned P_COUNT_BIT = 30,
  parameter int unsigned P_FREQ      = 100_000_000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_start,
  input  logic                   i_pause,
  input  logic                   i_clear,
  input  logic [6:0]             i_load_min,
  input  logic [5:0]             i_load_sec,
  input  logic                   i_tick,
  output logic                   o_run_en,
  output logic [P_COUNT_BIT-1:0] o_freq,
  output logic                   o_gen_reset,
  output logic [6:0]             o_min,
  output logic [5:0]             o_sec,
  output logic [1:0]             o_state,
  output logic                   o_done,
  output logic                   o_alarm
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [6:0] min_d;
  logic [5:0] sec_d;
  logic       run_en_d, gen_reset_d, done_d, alarm_d;

  // Clamped preset
  logic [6:0] clamp_min;
  logic [5:0] clamp_sec;
  logic       preset_zero;

  assign clamp_min   = (i_load_min > 7'd99) ? 7'd99 : i_load_min;
  assign clamp_sec   = (i_load_sec > 6'd59) ? 6'd59 : i_load_sec;
  assign preset_zero = (clamp_min == 7'd0) && (clamp_sec == 6'd0);

`ifdef AUTO_RELOAD_EN
  // Preset captured at the last start from IDLE, used for reload
  logic [6:0] pre_min_q, pre_min_d;
  logic [5:0] pre_sec_q, pre_sec_d;
`endif

  // One-second decrement of the current count
  logic [6:0] dec_min;
  logic [5:0] dec_sec;
  logic       dec_zero;

  always_comb begin
    dec_min = o_min;
    dec_sec = o_sec;
    if (o_sec != 6'd0) begin
      dec_sec = o_sec - 6'd1;
    end else if (o_min != 7'd0) begin
      dec_min = o_min - 7'd1;
      dec_sec = 6'd59;
    end
    dec_zero = (dec_min == 7'd0) && (dec_sec == 6'd0);
  end

  // State register and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      o_min       <= 7'd0;
      o_sec       <= 6'd0;
      o_run_en    <= 1'b0;
      o_gen_reset <= 1'b0;
      o_done      <= 1'b0;
      o_alarm     <= 1'b0;
      o_freq      <= P_COUNT_BIT'(P_FREQ);
`ifdef AUTO_RELOAD_EN
      pre_min_q   <= 7'd0;
      pre_sec_q   <= 6'd0;
`endif
    end else begin
      state_q     <= state_d;
      o_min       <= min_d;
      o_sec       <= sec_d;
      o_run_en    <= run_en_d;
      o_gen_reset <= gen_reset_d;
      o_done      <= done_d;
      o_alarm     <= alarm_d;
      o_freq      <= P_COUNT_BIT'(P_FREQ);
`ifdef AUTO_RELOAD_EN
      pre_min_q   <= pre_min_d;
      pre_sec_q   <= pre_sec_d;
`endif
    end
  end

  assign o_state = state_q;

  // Next state and next output values
  always_comb begin
    state_d     = state_q;
    min_d       = o_min;
    sec_d       = o_sec;
    gen_reset_d = 1'b0;
    done_d      = 1'b0;
`ifdef AUTO_RELOAD_EN
    pre_min_d   = pre_min_q;
    pre_sec_d   = pre_sec_q;
`endif

    if (i_clear) begin
      // Abort wins over everything; a coincident tick is dropped
      state_d     = S_IDLE;
      gen_reset_d = 1'b1;
      min_d       = clamp_min;
      sec_d       = clamp_sec;
    end else begin
      case (state_q)
        S_IDLE: begin
          min_d = clamp_min;
          sec_d = clamp_sec;
          if (i_start && !preset_zero) begin
            state_d     = S_RUN;
            gen_reset_d = 1'b1;
`ifdef AUTO_RELOAD_EN
            pre_min_d   = clamp_min;
            pre_sec_d   = clamp_sec;
`endif
          end
        end
        S_RUN: begin
          if (i_tick) begin
            min_d = dec_min;
            sec_d = dec_sec;
            if (dec_zero) begin
              done_d = 1'b1;
`ifdef AUTO_RELOAD_EN
              min_d  = pre_min_q;
              sec_d  = pre_sec_q;
`else
              state_d = S_DONE;
`endif
            end
          end
          // A coincident tick is still applied; completion outranks pause
          if (i_pause && (state_d == S_RUN)) begin
            state_d = S_PAUSE;
          end
        end
        S_PAUSE: begin
          if (i_start) begin
            state_d = S_RUN;
          end
        end
        S_DONE: begin
          min_d = 7'd0;
          sec_d = 6'd0;
          if (i_start) begin
            state_d = S_IDLE;
            min_d   = clamp_min;
            sec_d   = clamp_sec;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    run_en_d = (state_d == S_RUN);
    alarm_d  = (state_d == S_DONE);
  end

endmodule
